// File: rtl/spi_slave.sv
// spi_slave: synthesizable SPI responder, modes 0-3, MSB first.
// SCK/CS/MOSI are oversampled in the Clk domain through SYNC_STAGES flops.
// Ports:
//   Clk, Rst            system clock, async active-high reset
//   Mode                {CPOL,CPHA}, latched at CS fall
//   SCK, CS, MOSI       SPI inputs from the master (CS active-low)
//   MISO, MisoOe        serial data to master and its output enable
//   TxData, TxWr        one-entry TX holding buffer write port
//   TxReady             TX holding buffer empty
//   RxData, RxValid     last received frame and 1-Clk update pulse
//   Busy                frame in progress
//   TxUnderrun          1-Clk pulse: frame started with empty TX buffer
module spi_slave #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [1:0]        Mode,
    input  logic              SCK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MisoOe,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxWr,
    output logic              TxReady,
    output logic [DATA_W-1:0] RxData,
    output logic              RxValid,
    output logic              Busy,
    output logic              TxUnderrun
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic [1:0]             mode_r;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      tx_buf, tx_sh, rx_sh, load_word;
    logic                   sck_new, sck_old, cs_new, cs_old, mosi_bit;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   last_sample;

    // CS synchronizer resets high (deselected) so reset never fakes a CS fall
    // from the reset value itself.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end

    // Bit 0 is the newest stage; edges compare the last two stages, and MOSI
    // is taken from the same stage as the new SCK level so they stay aligned.
    assign sck_new  = sck_sync[SYNC_STAGES-2];
    assign sck_old  = sck_sync[SYNC_STAGES-1];
    assign cs_new   = cs_sync[SYNC_STAGES-2];
    assign cs_old   = cs_sync[SYNC_STAGES-1];
    assign mosi_bit = mosi_sync[SYNC_STAGES-2];

    assign sck_rise = sck_new & ~sck_old;
    assign sck_fall = ~sck_new & sck_old;
    assign cs_fall  = cs_old & ~cs_new;
    assign cs_rise  = ~cs_old & cs_new;

    assign lead_edge   = mode_r[1] ? sck_fall : sck_rise;
    assign trail_edge  = mode_r[1] ? sck_rise : sck_fall;
    assign sample_edge = mode_r[0] ? trail_edge : lead_edge;
    assign shift_edge  = mode_r[0] ? lead_edge : trail_edge;
    assign last_sample = (state == ACTIVE) && sample_edge && (bit_cnt == LAST_BIT);

    assign load_word = TxReady ? IDLE_BYTE : tx_buf;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = LOAD;
            LOAD:    state_nxt = cs_rise ? IDLE : ACTIVE;
            ACTIVE: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else if (last_sample) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mode_r     <= '0;
            bit_cnt    <= '0;
            tx_buf     <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            MISO       <= 1'b0;
            TxReady    <= 1'b1;
            RxData     <= '0;
            RxValid    <= 1'b0;
            TxUnderrun <= 1'b0;
        end else begin
            RxValid    <= 1'b0;
            TxUnderrun <= 1'b0;

            if (state == IDLE && cs_fall) begin
                mode_r <= Mode;
            end

            // LOAD empties a full buffer; a write in that cycle was refused
            // because TxReady was 0. With an empty buffer LOAD sends IDLE_BYTE
            // and a same-cycle write is kept for the next frame.
            if (state == LOAD && !TxReady) begin
                TxReady <= 1'b1;
            end else if (TxWr && TxReady) begin
                tx_buf  <= TxData;
                TxReady <= 1'b0;
            end

            if (cs_rise) begin
                bit_cnt <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        tx_sh <= load_word;
                        if (TxReady) begin
                            TxUnderrun <= 1'b1;
                        end
                        if (!mode_r[0]) begin
                            MISO <= load_word[DATA_W-1];
                        end
                    end
                    ACTIVE: begin
                        if (sample_edge) begin
                            rx_sh <= {rx_sh[DATA_W-2:0], mosi_bit};
                            if (bit_cnt == LAST_BIT) begin
                                RxData  <= {rx_sh[DATA_W-2:0], mosi_bit};
                                RxValid <= 1'b1;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        // With no sample yet in this frame the shift edge
                        // presents the MSB without consuming it; this covers
                        // CPHA=1 and the CPHA=0 trailing edge after a
                        // back-to-back reload.
                        if (shift_edge) begin
                            if (bit_cnt == '0) begin
                                MISO <= tx_sh[DATA_W-1];
                            end else begin
                                MISO  <= tx_sh[DATA_W-2];
                                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign MisoOe = (state != IDLE);
    assign Busy   = ((state != IDLE) && (bit_cnt != '0)) || (state == LOAD);

endmodule
